// File: rtl/rd_req_tracker_if.sv
// rd_req_tracker_if: request/response handshake bundle between the cross-bar
// slave port logic (master modport) and the outstanding-read tracker
// (slave modport).
interface rd_req_tracker_if #(
  parameter int NUM_MASTERS = 2,
  parameter int SEL_WIDTH   = $clog2(NUM_MASTERS)
);
  logic                   rd_req;
  logic [SEL_WIDTH-1:0]   rd_req_sel;
  logic                   rd_req_ready;
  logic [NUM_MASTERS-1:0] resp;
  logic [NUM_MASTERS-1:0] resp_en;
  logic                   err_unexpected;
  logic                   idle;

  modport master (
    output rd_req, rd_req_sel, resp,
    input  rd_req_ready, resp_en, err_unexpected, idle
  );

  modport slave (
    input  rd_req, rd_req_sel, resp,
    output rd_req_ready, resp_en, err_unexpected, idle
  );
endinterface

// File: rtl/rd_req_tracker.sv
// rd_req_tracker: per-master outstanding read counter for one cross-bar slave
// port. Counts accepted reads per target master, enables response acceptance
// per master and back-pressures new requests at the per-master limit.
// Optional feature macro RD_REQ_TRACK_ORDER_EN: adds an order queue so only
// the master holding the oldest outstanding request may respond; ready is
// then also gated by queue full.
module rd_req_tracker #(
  parameter int NUM_MASTERS     = 2,
  parameter int CNT_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 15,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic             aclk,
  input  logic             areset,
  rd_req_tracker_if.slave  bus
);
  localparam int SEL_WIDTH = $clog2(NUM_MASTERS);

  // Reject parameter sets the counters and queue cannot represent.
  if ((NUM_MASTERS < 2) || (MAX_OUTSTANDING < 1) ||
      (MAX_OUTSTANDING > ((2 ** CNT_WIDTH) - 1)) ||
      (FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_param_bad
    $error("rd_req_tracker: illegal parameter combination");
  end

  logic [CNT_WIDTH-1:0]   count_r     [NUM_MASTERS];
  logic [CNT_WIDTH-1:0]   count_nxt_s [NUM_MASTERS];
  logic [CNT_WIDTH-1:0]   sel_count_s;
  logic [NUM_MASTERS-1:0] sel_hit_s;
  logic                   sel_ok_s;
  logic                   full_s;
  logic                   accept_s;
  logic [NUM_MASTERS-1:0] accept_vec_s;
  logic [NUM_MASTERS-1:0] valid_resp_s;
  logic [NUM_MASTERS-1:0] resp_en_nxt_s;
  logic                   idle_nxt_s;
  logic [NUM_MASTERS-1:0] resp_en_r;
  logic                   err_r;
  logic                   idle_r;

  // Decode the target index; an index beyond NUM_MASTERS hits nothing.
  always_comb begin
    sel_count_s = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sel_hit_s[i] = (bus.rd_req_sel == SEL_WIDTH'(i));
      sel_count_s  = sel_count_s | (sel_hit_s[i] ? count_r[i] : '0);
    end
    sel_ok_s = |sel_hit_s;
  end

  assign bus.rd_req_ready = !areset && sel_ok_s && !full_s &&
                            (sel_count_s != CNT_WIDTH'(MAX_OUTSTANDING));
  assign accept_s     = bus.rd_req & bus.rd_req_ready;
  assign accept_vec_s = sel_hit_s & {NUM_MASTERS{accept_s}};
  assign valid_resp_s = bus.resp & resp_en_r;

  // Next-state counters: up on accept, down on valid response, hold on both.
  always_comb begin
    idle_nxt_s = 1'b1;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      case ({accept_vec_s[i], valid_resp_s[i]})
        2'b10:   count_nxt_s[i] = count_r[i] + CNT_WIDTH'(1);
        2'b01:   count_nxt_s[i] = count_r[i] - CNT_WIDTH'(1);
        default: count_nxt_s[i] = count_r[i];
      endcase
      idle_nxt_s = idle_nxt_s & (count_nxt_s[i] == '0);
    end
  end

`ifdef RD_REQ_TRACK_ORDER_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [SEL_WIDTH-1:0] fifo_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [PTR_W:0]       occ_r;
  logic [PTR_W-1:0]     rd_ptr_nxt_s;
  logic [PTR_W:0]       occ_nxt_s;
  logic [PTR_W:0]       remain_s;
  logic [SEL_WIDTH-1:0] head_nxt_s;
  logic                 pop_s;

  // Only the head master is ever enabled, so any valid response is a pop.
  assign pop_s  = |valid_resp_s;
  assign full_s = (occ_r == (PTR_W + 1)'(FIFO_DEPTH));

  // Queue next state and the head it will present after this edge.
  always_comb begin
    rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
    remain_s     = occ_r - (PTR_W + 1)'(pop_s);
    occ_nxt_s    = remain_s + (PTR_W + 1)'(accept_s);
    // When nothing older survives, the head is the entry being pushed now.
    if (remain_s == '0) begin
      head_nxt_s = bus.rd_req_sel;
    end else begin
      head_nxt_s = fifo_r[rd_ptr_nxt_s];
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      resp_en_nxt_s[i] = (occ_nxt_s != '0) && (head_nxt_s == SEL_WIDTH'(i));
    end
  end

  // Order queue storage and pointers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      if (accept_s) begin
        fifo_r[wr_ptr_r] <= bus.rd_req_sel;
        wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      occ_r    <= occ_nxt_s;
    end
  end
`else
  assign full_s = 1'b0;

  // Any master with reads in flight may respond, independently of the others.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      resp_en_nxt_s[i] = (count_nxt_s[i] != '0);
    end
  end
`endif

  // Counter and registered status outputs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        count_r[i] <= '0;
      end
      resp_en_r <= '0;
      err_r     <= 1'b0;
      idle_r    <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        count_r[i] <= count_nxt_s[i];
      end
      resp_en_r <= resp_en_nxt_s;
      err_r     <= |(bus.resp & ~resp_en_r);
      idle_r    <= idle_nxt_s;
    end
  end

  assign bus.resp_en        = resp_en_r;
  assign bus.err_unexpected = err_r;
  assign bus.idle           = idle_r;
endmodule

// File: doc/rd_req_tracker.md
# rd_req_tracker

Parametrised outstanding-read tracker for one slave port of the cross bar, generalising the two-master read request counter to NUM_MASTERS channels. It counts accepted read requests per target master, gates response acceptance per master via `resp_en`, and back-pressures new requests when a per-master limit or the order queue is full. An optional order queue restricts response acceptance to the master holding the oldest outstanding request.

## Interface
- NUM_MASTERS, 2, number of master ports tracked (≥2)
- CNT_WIDTH, 8, width of each per-master counter
- MAX_OUTSTANDING, 15, per-master limit; must be ≤ 2^CNT_WIDTH−1
- FIFO_DEPTH, 16, order-queue depth, power of two (used only with order mode)
- SEL_WIDTH, $clog2(NUM_MASTERS), derived, not overridden
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- rd_req  in  1  read request offered this cycle (req & !cmd & ack at slave side)
- rd_req_sel  in  SEL_WIDTH  target master index of the offered request
- rd_req_ready  out  1  request may be accepted this cycle (combinational)
- resp  in  NUM_MASTERS  one-hot-per-master final response beat from master i
- resp_en  out  NUM_MASTERS  registered, master i's responses may be passed to this slave
- err_unexpected  out  1  registered one-cycle pulse: response seen while its resp_en was low
- idle  out  1  registered, all counters zero

## Operation
- Accept = rd_req & rd_req_ready. A request offered with ready low is dropped (no state change, no error).
- rd_req_ready = !areset & count[rd_req_sel] != MAX_OUTSTANDING & (order mode: queue not full). rd_req_sel ≥ NUM_MASTERS → ready low.
- Valid response from master i = resp[i] & resp_en[i]. Invalid responses are ignored and set err_unexpected next cycle.
- Per-master counter i: +1 on accept to i, −1 on valid response from i, unchanged if both or neither. Never wraps: cannot exceed MAX_OUTSTANDING (ready gating) or go below 0 (resp_en gating).
- Unordered mode: resp_en[i] = (count[i] != 0), evaluated on next-state counters; multiple masters may be enabled and respond in the same cycle.
- Order mode: accept pushes rd_req_sel into the queue; valid response pops the head. resp_en is one-hot on the head index when the queue is non-empty, else all zero. Push and pop in the same cycle are both performed (occupancy unchanged).
- idle = all next-state counters zero.

## Timing
- Reset (async assert, sync release): counters 0, queue empty, resp_en = 0, err_unexpected = 0, idle = 1. rd_req_ready = 0 while areset is high.
- Reset mid-operation discards all outstanding state immediately; a late response after release raises err_unexpected.
- Accept at edge t → resp_en for that master high after edge t (visible cycle t+1); idle low at t+1.
- Last valid response at edge t → resp_en low at t+1 (unordered), or moves to the new head at t+1 (order mode). The same head master repeated keeps resp_en high with no bubble.
- A full counter/queue decremented at edge t → rd_req_ready high in cycle t+1.
- err_unexpected: response in cycle t with resp_en low → pulse for exactly cycle t+1.

## Configuration
- RD_REQ_TRACK_ORDER_EN defined: order queue built; in-order resp_en, ready also gated by queue full.
- Not defined: no queue logic; resp_en per nonzero counter; FIFO_DEPTH unused.

## Test plan
- Reset then NUM_MASTERS=4: 3 accepts to master 2 → resp_en = 4'b0100 at cycle after first accept, idle = 0; 3 valid responses → resp_en = 0, idle = 1 one cycle after last.
- MAX_OUTSTANDING=15: 15 accepts to master 1 → rd_req_ready low for sel = 1, high for sel = 0; simultaneous accept to 1 and response from 1 at count 14 → count stays 14.
- resp[3] pulsed with count[3] = 0 → err_unexpected high for one cycle, counters unchanged.
- Order mode: accepts to masters 1, 0, 1 → resp_en = 2'b10; resp[0] asserted → error, ignored; resp[1] → resp_en = 2'b01 next cycle.
- Order mode, FIFO_DEPTH=4: 4 accepts → ready low; a pop and an offered push in the same cycle → push accepted only in the cycle after the pop, occupancy returns to 4.
- areset asserted asynchronously with 5 outstanding → all outputs reset values immediately; post-release response → err_unexpected pulse.
